// File: rtl/qstat_pkg.sv
// Shared types for qstat: stream element/result layouts at default widths and the FSM state.
// Widths are parameters of qstat, so the top declares width-matched copies of these structs.
package qstat_pkg;

  localparam int W_DATA_DEF = 16;
  localparam int W_SUM_DEF  = 32;
  localparam int W_CNT_DEF  = 16;

  // eot is the MSB, matching the range generator's output struct
  typedef struct packed {
    logic                  eot;
    logic [W_DATA_DEF-1:0] data;
  } din_t;

  typedef struct packed {
    logic [W_DATA_DEF-1:0] max;
    logic [W_DATA_DEF-1:0] min;
    logic [W_CNT_DEF-1:0]  cnt;
    logic [W_SUM_DEF-1:0]  sum;
  } dout_t;

  typedef enum logic {ACC = 1'b0, HOLD = 1'b1} state_t;

endpackage

// File: rtl/qstat_minmax.sv
// Combinational min/max fold of one element into the running extremes.
// The first element of a transaction seeds both extremes.
module qstat_minmax #(
  parameter int W_DATA = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic [W_DATA-1:0] cur_min,
  input  logic [W_DATA-1:0] cur_max,
  input  logic [W_DATA-1:0] data,
  input  logic              first,
  output logic [W_DATA-1:0] nxt_min,
  output logic [W_DATA-1:0] nxt_max
);

  logic lt, gt;

  generate
    if (SIGNED) begin : g_signed
      assign lt = $signed(data) < $signed(cur_min);
      assign gt = $signed(data) > $signed(cur_max);
    end else begin : g_unsigned
      assign lt = data < cur_min;
      assign gt = data > cur_max;
    end
  endgenerate

  always_comb begin
    nxt_min = cur_min;
    nxt_max = cur_max;
    if (first || lt) nxt_min = data;
    if (first || gt) nxt_max = data;
  end

endmodule

// File: rtl/qstat.sv
// Reduces each eot-terminated stream transaction to one {max, min, cnt, sum} word.
// One-deep output register; a new result may reload it in the same cycle it is consumed.
module qstat
  import qstat_pkg::*;
#(
  parameter int W_DATA = 16,
  parameter int W_SUM  = 32,
  parameter int W_CNT  = 16,
  parameter bit SIGNED = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             din_valid,
  output logic                             din_ready,
  input  logic [W_DATA:0]                  din_data,
  output logic                             dout_valid,
  input  logic                             dout_ready,
  output logic [2*W_DATA+W_CNT+W_SUM-1:0]  dout_data
);

  typedef struct packed {
    logic              eot;
    logic [W_DATA-1:0] data;
  } din_w_t;

  typedef struct packed {
    logic [W_DATA-1:0] max;
    logic [W_DATA-1:0] min;
    logic [W_CNT-1:0]  cnt;
    logic [W_SUM-1:0]  sum;
  } dout_w_t;

  if (W_SUM < W_DATA) begin : g_bad_sum
    $fatal(1, "qstat: W_SUM (%0d) must be >= W_DATA (%0d)", W_SUM, W_DATA);
  end
  if ($bits(din_data) != W_DATA + 1) begin : g_bad_din
    $fatal(1, "qstat: din_data width mismatch");
  end
  if ($bits(dout_data) != 2*W_DATA + W_CNT + W_SUM) begin : g_bad_dout
    $fatal(1, "qstat: dout_data width mismatch");
  end

  state_t            state, state_nxt;
  din_w_t            din;
  dout_w_t           out_q;
  logic [W_SUM-1:0]  sum_q, sum_nxt, ext;
  logic [W_CNT-1:0]  cnt_q, cnt_nxt;
  logic [W_DATA-1:0] min_q, max_q, min_nxt, max_nxt;
  logic              first_q;
  logic              hs_in, hs_eot;

  assign din        = din_w_t'(din_data);
  assign dout_valid = (state == HOLD);
  assign din_ready  = ~dout_valid | dout_ready;
  assign hs_in      = din_valid & din_ready;
  assign hs_eot     = hs_in & din.eot;
  assign dout_data  = out_q;

  generate
    if (SIGNED) begin : g_sext
      assign ext = W_SUM'($signed(din.data));
    end else begin : g_zext
      assign ext = W_SUM'(din.data);
    end
  endgenerate

  assign sum_nxt = sum_q + ext;
  assign cnt_nxt = (cnt_q == {W_CNT{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  qstat_minmax #(.W_DATA(W_DATA), .SIGNED(SIGNED)) u_minmax (
    .cur_min (min_q),
    .cur_max (max_q),
    .data    (din.data),
    .first   (first_q),
    .nxt_min (min_nxt),
    .nxt_max (max_nxt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ACC:  if (hs_eot) state_nxt = HOLD;
      HOLD: if (dout_ready && !hs_eot) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ACC;
      sum_q   <= '0;
      cnt_q   <= '0;
      min_q   <= '0;
      max_q   <= '0;
      first_q <= 1'b1;
      out_q   <= '0;
    end else begin
      state <= state_nxt;
      if (hs_eot) begin
        // closing element is folded straight into the result; accumulators restart
        out_q   <= '{max: max_nxt, min: min_nxt, cnt: cnt_nxt, sum: sum_nxt};
        sum_q   <= '0;
        cnt_q   <= '0;
        first_q <= 1'b1;
      end else if (hs_in) begin
        sum_q   <= sum_nxt;
        cnt_q   <= cnt_nxt;
        min_q   <= min_nxt;
        max_q   <= max_nxt;
        first_q <= 1'b0;
      end
    end
  end

endmodule
